// File: rtl/vtpg_pkg.sv
// Shared definitions for the multi-pattern video test pattern generator.
// Pixel layout is {B[23:16], R[15:8], G[7:0]}.
package vtpg_pkg;

  localparam logic [23:0] C_GRN = 24'h0000FF;
  localparam logic [23:0] C_RED = 24'h00FF00;
  localparam logic [23:0] C_BLU = 24'hFF0000;
  localparam logic [23:0] C_WHT = 24'hFFFFFF;
  localparam logic [23:0] C_BLK = 24'h000000;
  localparam logic [23:0] C_YEL = 24'h00FFFF;
  localparam logic [23:0] C_CYN = 24'hFF00FF;
  localparam logic [23:0] C_MAG = 24'hFFFF00;

  typedef enum logic [2:0] {
    M_SOLID = 3'd0,
    M_QUAD  = 3'd1,
    M_BARS  = 3'd2,
    M_CHECK = 3'd3,
    M_RAMP  = 3'd4
  } tpg_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    STOP
  } tpg_state_t;

endpackage

// File: rtl/vtpg_pixel.sv
// Combinational colour generator for one pixel.
// Ports:
//   i_mode  pattern select (5-7 behave as solid)
//   i_col   pattern column (already scrolled when scrolling is enabled)
//   i_y     line number
//   i_w     active width, i_h active height
//   i_solid colour for solid mode
//   o_pix   resulting pixel
module vtpg_pixel
  import vtpg_pkg::*;
#(
  parameter int PIXW = 24
) (
  input  logic [2:0]      i_mode,
  input  logic [12:0]     i_col,
  input  logic [12:0]     i_y,
  input  logic [12:0]     i_w,
  input  logic [12:0]     i_h,
  input  logic [PIXW-1:0] i_solid,
  output logic [PIXW-1:0] o_pix
);

  logic [15:0] w_col8;
  logic [2:0]  w_bar;
  logic [23:0] w_bar_rgb;
  logic [23:0] w_rgb;
  logic        w_use_solid;

  // Bar index = floor(col*8/W), found as the number of k in 1..7 with k*W <= col*8,
  // which needs only 16-bit multiplies by small constants instead of a divider.
  always_comb begin
    w_col8 = {i_col, 3'b000};
    w_bar  = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (w_col8 >= 16'(k) * {3'b000, i_w}) w_bar = 3'(k);
    end
  end

  always_comb begin
    case (w_bar)
      3'd0:    w_bar_rgb = C_WHT;
      3'd1:    w_bar_rgb = C_YEL;
      3'd2:    w_bar_rgb = C_CYN;
      3'd3:    w_bar_rgb = C_GRN;
      3'd4:    w_bar_rgb = C_MAG;
      3'd5:    w_bar_rgb = C_RED;
      3'd6:    w_bar_rgb = C_BLU;
      default: w_bar_rgb = C_BLK;
    endcase
  end

  always_comb begin
    w_rgb       = C_BLK;
    w_use_solid = 1'b0;
    case (i_mode)
      M_QUAD: begin
        if (i_y < (i_h >> 1))      w_rgb = C_GRN;
        else if (i_col < (i_w >> 1)) w_rgb = C_RED;
        else                       w_rgb = C_BLU;
      end
      M_BARS:  w_rgb = w_bar_rgb;
      M_CHECK: w_rgb = (i_col[5] ^ i_y[5]) ? C_WHT : C_BLK;
      M_RAMP:  w_rgb = {3{i_col[7:0]}};
      default: w_use_solid = 1'b1;
    endcase
  end

  assign o_pix = w_use_solid ? i_solid : PIXW'(w_rgb);

endmodule

// File: rtl/video_tpg_mp.sv
// Multi-pattern, multi-pixel-per-clock AXI4-Stream video test pattern generator.
// Ports:
//   clk, rst (async, active high), en (run request level)
//   cfg_mode/cfg_width/cfg_height/cfg_solid  runtime config, sampled at frame starts
//   m_axis_*   AXI4-Stream master (tuser = SOF, tlast = EOL, tkeep all ones)
//   frame_done 1-cycle pulse after the last beat of a frame is accepted
//   frame_cnt  completed frames (wrapping), busy = FSM not idle
// Optional: define VIDEO_TPG_SCROLL_EN to scroll pattern content left by one
// beat per frame.
module video_tpg_mp
  import vtpg_pkg::*;
#(
  parameter int PPC   = 1,
  parameter int PIXW  = 24,
  parameter int DATAW = PPC * PIXW,
  parameter int SCRW  = 1280,
  parameter int SCRH  = 720
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2:0]         cfg_mode,
  input  logic [12:0]        cfg_width,
  input  logic [12:0]        cfg_height,
  input  logic [PIXW-1:0]    cfg_solid,
  output logic [DATAW-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tuser,
  output logic               m_axis_tlast,
  output logic [DATAW/8-1:0] m_axis_tkeep,
  output logic               frame_done,
  output logic [15:0]        frame_cnt,
  output logic               busy
);

  localparam logic [12:0] PPC13  = 13'(PPC);
  localparam logic [12:0] WMASK  = ~(PPC13 - 13'd1);
  localparam logic [12:0] MINW   = 13'(2 * PPC);

  tpg_state_t       r_state;
  logic [12:0]      r_x, r_y, r_w, r_h;
  logic [2:0]       r_mode;
  logic [PIXW-1:0]  r_solid;
  logic             r_drain;
  logic [DATAW-1:0] r_tdata;
  logic             r_tvalid, r_tuser, r_tlast, r_oeof;
  logic             r_done;
  logic [15:0]      r_frame_cnt;

  logic [12:0]      w_wr, w_eff_w, w_eff_h;
  logic             w_last_x, w_last_y, w_eof;
  logic             w_prod, w_ld, w_emit, w_acc, w_latch;
  logic [DATAW-1:0] w_pix;

  always_comb begin
    w_wr    = cfg_width & WMASK;
    w_eff_w = (cfg_width == '0) ? 13'(SCRW) : ((w_wr < MINW) ? MINW : w_wr);
    w_eff_h = (cfg_height == '0) ? 13'(SCRH) :
              ((cfg_height < 13'd2) ? 13'd2 : cfg_height);
  end

  assign w_last_x = (r_x == r_w - PPC13);
  assign w_last_y = (r_y == r_h - 13'd1);
  assign w_eof    = w_last_x && w_last_y;

  // The counters address the next beat to be loaded into the output register;
  // r_drain marks that the final beat of a stopping frame is already loaded.
  assign w_prod = (r_state != IDLE) && !r_drain;
  assign w_ld   = !r_tvalid || m_axis_tready;
  assign w_emit = w_ld && w_prod;
  assign w_acc  = r_tvalid && m_axis_tready;

  // Shadow config reloads only at a frame start: leaving IDLE, wrapping into the
  // next frame while still enabled, or restarting from a drained STOP.
  assign w_latch = en && ((r_state == IDLE) || (w_emit && w_eof) ||
                          ((r_state == STOP) && r_drain));

`ifdef VIDEO_TPG_SCROLL_EN
  logic [12:0] r_off;
  logic [12:0] w_off_inc, w_off_nxt, w_off_lat, w_off_keep;

  always_comb begin
    w_off_inc  = r_off + PPC13;
    w_off_nxt  = (w_off_inc >= r_w) ? (w_off_inc - r_w) : w_off_inc;
    // Keep the offset inside a newly latched (possibly narrower) width.
    w_off_lat  = (w_off_nxt >= w_eff_w) ? '0 : w_off_nxt;
    w_off_keep = (r_off >= w_eff_w) ? '0 : r_off;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_off <= '0;
    end else if (w_emit && w_eof) begin
      r_off <= w_latch ? w_off_lat : w_off_nxt;
    end else if (w_latch) begin
      r_off <= w_off_keep;
    end
  end
`endif

  for (genvar p = 0; p < PPC; p++) begin : g_pix
    logic [12:0] w_col;
`ifdef VIDEO_TPG_SCROLL_EN
    logic [13:0] w_sum;
    always_comb begin
      w_sum = {1'b0, r_x} + 14'(p) + {1'b0, r_off};
      w_col = (w_sum >= {1'b0, r_w}) ? 13'(w_sum - {1'b0, r_w}) : w_sum[12:0];
    end
`else
    assign w_col = r_x + 13'(p);
`endif

    vtpg_pixel #(.PIXW(PIXW)) u_pix (
      .i_mode  (r_mode),
      .i_col   (w_col),
      .i_y     (r_y),
      .i_w     (r_w),
      .i_h     (r_h),
      .i_solid (r_solid),
      .o_pix   (w_pix[p*PIXW +: PIXW])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_mode      <= '0;
      r_solid     <= '0;
      r_drain     <= 1'b0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tuser     <= 1'b0;
      r_tlast     <= 1'b0;
      r_oeof      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_done <= w_acc && r_oeof;
      if (w_acc && r_oeof) r_frame_cnt <= r_frame_cnt + 16'd1;

      if (w_ld) begin
        r_tvalid <= w_emit;
        if (w_emit) begin
          r_tdata <= w_pix;
          r_tuser <= (r_x == '0) && (r_y == '0);
          r_tlast <= w_last_x;
          r_oeof  <= w_eof;
        end else begin
          r_tuser <= 1'b0;
          r_tlast <= 1'b0;
          r_oeof  <= 1'b0;
        end
      end

      if (w_latch) begin
        r_w     <= w_eff_w;
        r_h     <= w_eff_h;
        r_mode  <= cfg_mode;
        r_solid <= cfg_solid;
        r_x     <= '0;
        r_y     <= '0;
        r_drain <= 1'b0;
      end else if (w_emit) begin
        if (w_eof) begin
          r_drain <= 1'b1;
        end else if (w_last_x) begin
          r_x <= '0;
          r_y <= r_y + 13'd1;
        end else begin
          r_x <= r_x + PPC13;
        end
      end

      case (r_state)
        IDLE:    if (en) r_state <= ACTIVE;
        ACTIVE:  if (!en) r_state <= STOP;
        STOP: begin
          if (en)                  r_state <= ACTIVE;
          else if (r_drain && w_acc) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tkeep  = '1;
  assign frame_done    = r_done;
  assign frame_cnt     = r_frame_cnt;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_video_tpg_mp.sv
// Directed bench for video_tpg_mp: a 1-pixel-per-clock instance and a
// 4-pixel-per-clock instance share clock, reset and config inputs.
module tb_video_tpg_mp;

  localparam logic [23:0] GRN = 24'h0000FF;
  localparam logic [23:0] RED = 24'h00FF00;
  localparam logic [23:0] BLU = 24'hFF0000;
  localparam logic [23:0] WHT = 24'hFFFFFF;
  localparam logic [23:0] BLK = 24'h000000;
  localparam logic [23:0] YEL = 24'h00FFFF;
  localparam logic [23:0] CYN = 24'hFF00FF;
  localparam logic [23:0] MAG = 24'hFFFF00;

  logic        clk = 1'b0;
  logic        rst, en, en4, tready, tready4;
  logic [2:0]  cfg_mode;
  logic [12:0] cfg_width, cfg_height;
  logic [23:0] cfg_solid;

  logic [23:0] tdata;
  logic        tvalid, tuser, tlast, fdone, busy;
  logic [2:0]  tkeep;
  logic [15:0] fcnt;

  logic [95:0] tdata4;
  logic        tvalid4, tuser4, tlast4, fdone4, busy4;
  logic [11:0] tkeep4;
  logic [15:0] fcnt4;

  logic [23:0] cap [0:16383];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  video_tpg_mp #(.PPC(1), .PIXW(24), .DATAW(24), .SCRW(1280), .SCRH(720)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_mode(cfg_mode), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .cfg_solid(cfg_solid), .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tuser(tuser),
    .m_axis_tlast(tlast), .m_axis_tkeep(tkeep), .frame_done(fdone),
    .frame_cnt(fcnt), .busy(busy)
  );

  video_tpg_mp #(.PPC(4), .PIXW(24), .DATAW(96), .SCRW(1280), .SCRH(720)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .cfg_mode(cfg_mode), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .cfg_solid(cfg_solid), .m_axis_tdata(tdata4),
    .m_axis_tvalid(tvalid4), .m_axis_tready(tready4), .m_axis_tuser(tuser4),
    .m_axis_tlast(tlast4), .m_axis_tkeep(tkeep4), .frame_done(fdone4),
    .frame_cnt(fcnt4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_pix(input int mode, input int col, input int y,
                                          input int w, input int h, input logic [23:0] solid);
    logic [7:0] c;
    case (mode)
      1: return (y < h / 2) ? GRN : ((col < w / 2) ? RED : BLU);
      2: begin
        case ((col * 8) / w)
          0: return WHT;
          1: return YEL;
          2: return CYN;
          3: return GRN;
          4: return MAG;
          5: return RED;
          6: return BLU;
          default: return BLK;
        endcase
      end
      3: return ((((col >> 5) ^ (y >> 5)) & 1) != 0) ? WHT : BLK;
      4: begin
        c = 8'(col);
        return {c, c, c};
      end
      default: return solid;
    endcase
  endfunction

  // Accepts one frame from dut, checking every beat against the model and
  // checking that a stalled beat holds its data/tuser/tlast.
  task automatic scan_frame(input string tag, input int w, input int h, input int mode,
                            input logic [23:0] solid, input int off, input int rdy_pct,
                            input int drop_en_at, input int poke_at, input logic [2:0] poke_mode);
    int x, y, beats, perrs, serrs, cyc, budget, col;
    bit fin, stalled;
    logic [23:0] pd, ex;
    logic pu, pl, eu, el;
    x = 0; y = 0; beats = 0; perrs = 0; serrs = 0; cyc = 0;
    fin = 0; stalled = 0; pd = '0; pu = 0; pl = 0;
    budget = w * h * 8 + 50;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (stalled && (tvalid !== 1'b1 || tdata !== pd || tuser !== pu || tlast !== pl)) serrs++;
      tready = ($urandom_range(0, 99) < rdy_pct);
      if (tvalid && tready) begin
        col = (x + off) % w;
        ex  = ref_pix(mode, col, y, w, h, solid);
        eu  = (x == 0 && y == 0);
        el  = (x == w - 1);
        if (tdata !== ex || tuser !== eu || tlast !== el) perrs++;
        if (y * w + x < 16384) cap[y * w + x] = tdata;
        beats++;
        if (beats == drop_en_at) en = 1'b0;
        if (beats == poke_at) cfg_mode = poke_mode;
        if (x == w - 1) begin
          x = 0;
          if (y == h - 1) fin = 1;
          else y++;
        end else begin
          x++;
        end
      end
      stalled = tvalid && !tready;
      pd = tdata; pu = tuser; pl = tlast;
    end
    check({tag, "_beats"}, beats, w * h);
    check({tag, "_pix"}, perrs, 0);
    check({tag, "_stall"}, serrs, 0);
  endtask

  // Called right after the last beat of a stopping frame was accepted.
  task automatic post_frame(input string tag, input logic [15:0] exp_cnt);
    @(negedge clk);
    check({tag, "_done"}, fdone, 1'b1);
    check({tag, "_valid_off"}, tvalid, 1'b0);
    check({tag, "_cnt"}, fcnt, exp_cnt);
    @(negedge clk);
    check({tag, "_done_pulse"}, fdone, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; en4 = 1'b0; tready = 1'b0; tready4 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, errs, off2;
    logic [95:0] exp4;
    cfg_mode = 3'd0; cfg_width = '0; cfg_height = '0; cfg_solid = 24'h123456;
    rst = 1'b1; en = 1'b0; en4 = 1'b0; tready = 1'b0; tready4 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {tvalid, tuser, tlast, fdone, busy, fcnt, tdata}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Default width, quad pattern, two lines.
    cfg_mode = 3'd1; cfg_width = 13'd0; cfg_height = 13'd2; en = 1'b1;
    scan_frame("dflt_w", 1280, 2, 1, cfg_solid, 0, 100, 1, -1, 3'd0);
    check("dflt_w_row0", cap[0], GRN);
    check("dflt_w_red", cap[1280 + 639], RED);
    check("dflt_w_blu", cap[1280 + 640], BLU);
    post_frame("dflt_w", 16'd1);

    // Default height, quad pattern, narrow lines.
    do_reset();
    cfg_mode = 3'd1; cfg_width = 13'd16; cfg_height = 13'd0; en = 1'b1;
    scan_frame("dflt_h", 16, 720, 1, cfg_solid, 0, 100, 1, -1, 3'd0);
    check("dflt_h_row359", cap[359 * 16 + 15], GRN);
    check("dflt_h_r360c7", cap[360 * 16 + 7], RED);
    check("dflt_h_r360c8", cap[360 * 16 + 8], BLU);
    post_frame("dflt_h", 16'd1);

    // Random backpressure on a 16x4 frame.
    do_reset();
    cfg_mode = 3'd1; cfg_width = 13'd16; cfg_height = 13'd4; en = 1'b1;
    scan_frame("bp50", 16, 4, 1, cfg_solid, 0, 50, 1, -1, 3'd0);
    post_frame("bp50", 16'd1);

    // en dropped mid-frame: frame still completes, then output stops.
    do_reset();
    cfg_mode = 3'd4; cfg_width = 13'd16; cfg_height = 13'd4; en = 1'b1;
    scan_frame("stop10", 16, 4, 4, cfg_solid, 0, 100, 10, -1, 3'd0);
    post_frame("stop10", 16'd1);
    repeat (4) @(negedge clk);
    check("stop10_stays_idle", tvalid, 1'b0);

    // Asynchronous reset in the middle of a running frame.
    en = 1'b1; tready = 1'b1;
    repeat (20) @(negedge clk);
    check("pre_rst_valid", tvalid, 1'b1);
    #1 rst = 1'b1;
    #1 check("rst_async", {tvalid, tuser, tlast, fdone, busy, fcnt, tdata}, '0);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    @(negedge clk);

    // Below-minimum size clamps to 2x2; solid colour.
    do_reset();
    cfg_mode = 3'd0; cfg_width = 13'd1; cfg_height = 13'd1; cfg_solid = 24'hA5C3E1; en = 1'b1;
    scan_frame("min2x2", 2, 2, 0, 24'hA5C3E1, 0, 100, 1, -1, 3'd0);
    post_frame("min2x2", 16'd1);

    // Colour bars; a mid-frame mode change only lands on the next SOF.
    do_reset();
    cfg_mode = 3'd2; cfg_width = 13'd64; cfg_height = 13'd2; en = 1'b1;
    scan_frame("bars", 64, 2, 2, cfg_solid, 0, 100, -1, 5, 3'd4);
    check("bars_c0", cap[0], WHT);
    check("bars_c8", cap[8], YEL);
    check("bars_c16", cap[16], CYN);
    check("bars_c63", cap[63], BLK);
`ifdef VIDEO_TPG_SCROLL_EN
    off2 = 1;
`else
    off2 = 0;
`endif
    scan_frame("ramp_next", 64, 2, 4, cfg_solid, off2, 100, 1, -1, 3'd0);
    post_frame("ramp_next", 16'd2);

    // Four pixels per beat, width 18 rounds down to 16.
    do_reset();
    cfg_mode = 3'd4; cfg_width = 13'd18; cfg_height = 13'd2; en4 = 1'b1; tready4 = 1'b1;
    cyc = 0;
    while (tvalid4 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ppc4_start", tvalid4, 1'b1);
    errs = 0;
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < 4; p++) begin
        exp4[p * 24 +: 24] = {3{8'((k % 4) * 4 + p)}};
      end
      if (tdata4 !== exp4 || tuser4 !== (k == 0) || tlast4 !== ((k % 4) == 3)) errs++;
      if (k == 0) begin
        check("ppc4_beat0", tdata4, 96'h030303_020202_010101_000000);
        en4 = 1'b0;
      end
      @(negedge clk);
    end
    check("ppc4_beats", errs, 0);
    check("ppc4_keep", tkeep4, 12'hFFF);
    check("ppc4_done", {fdone4, tvalid4, fcnt4}, {1'b1, 1'b0, 16'd1});

`ifdef VIDEO_TPG_SCROLL_EN
    // Scroll: content moves one column left per frame, wrapping at W.
    do_reset();
    cfg_mode = 3'd4; cfg_width = 13'd16; cfg_height = 13'd2; en = 1'b1;
    for (int f = 1; f <= 17; f++) begin
      scan_frame("scroll", 16, 2, 4, cfg_solid, (f - 1) % 16, 100, (f == 17) ? 1 : -1, -1, 3'd0);
      if (f == 2) check("scroll_f2_b0", cap[0], 24'h010101);
    end
    check("scroll_f17_b0", cap[0], 24'h000000);
    post_frame("scroll", 16'd17);
`endif

    // Frame counter wrap.
    do_reset();
    force dut.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_cnt;
    @(negedge clk);
    check("wrap_pre", fcnt, 16'hFFFF);
    cfg_mode = 3'd0; cfg_width = 13'd2; cfg_height = 13'd2; cfg_solid = 24'h00AA55; en = 1'b1;
    scan_frame("wrap", 2, 2, 0, 24'h00AA55, 0, 100, 1, -1, 3'd0);
    post_frame("wrap", 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
